// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// data_mem_responder_pkg: shared load/store handshake structs and responder state encoding.
// Revision 1.0
package data_mem_responder_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dmem_state_e;

  function automatic logic [3:0] byte_enables(input logic byte_not_word, input logic [1:0] lane);
    return byte_not_word ? (4'b0001 << lane) : 4'b1111;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// data_mem_responder_if: request/response bundle between the core and the data-memory responder.
// Revision 1.0
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  mem_in_s     to_mem_i;
  logic [31:0] addr_i;
  mem_out_s    from_mem_o;

  modport master (output to_mem_i, output addr_i, input from_mem_o);
  modport slave  (input to_mem_i, input addr_i, output from_mem_o);
endinterface
`default_nettype wire

// File: rtl/data_mem_responder_dmem_array.sv
`default_nettype none
// dmem_array: single-port 32-bit word array with per-byte write enables and registered read.
// Revision 1.0
module dmem_array #(
  parameter int addr_width_p = 10
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  input  wire logic                    en,
  input  wire logic [3:0]              we,
  input  wire logic [addr_width_p-1:0] addr,
  input  wire logic [31:0]             wdata,
  output logic      [31:0]             rdata
);

  // Storage is deliberately not reset so contents survive a reset pulse.
  logic [31:0] mem [2**addr_width_p];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// data_mem_responder: accepts one load/store, performs it on the internal array, and holds
// the response until the core acknowledges. Revision 1.0
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  data_mem_responder_if.slave   mem_if,
  output logic                  busy_o
);

  localparam int cnt_w_lp = $clog2(latency_p + 1);

  if (latency_p < 1) begin : g_bad_latency
    $error("data_mem_responder: latency_p must be at least 1");
  end

  dmem_state_e           state_r, state_n;
  logic [cnt_w_lp-1:0]   count_r, count_n;
  logic                  accept;
  logic                  wen_r, byte_r;
  logic [1:0]            lane_r;
  logic [31:0]           array_rdata;
  logic [31:0]           read_data;
  logic [addr_width_p-1:0] word_idx;
  logic [3:0]            byte_we;
  logic [31:0]           wdata;
  logic                  unused_addr_bits;

  // Upper address bits alias onto the array.
  assign word_idx         = mem_if.addr_i[addr_width_p+1:2];
  assign unused_addr_bits = ^mem_if.addr_i[31:addr_width_p+2];

  assign byte_we = (accept && mem_if.to_mem_i.wen)
                 ? byte_enables(mem_if.to_mem_i.byte_not_word, mem_if.addr_i[1:0])
                 : 4'b0000;
  assign wdata   = mem_if.to_mem_i.byte_not_word
                 ? {4{mem_if.to_mem_i.write_data[7:0]}}
                 : mem_if.to_mem_i.write_data;

  dmem_array #(.addr_width_p(addr_width_p)) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .we    (byte_we),
    .addr  (word_idx),
    .wdata (wdata),
    .rdata (array_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= DM_IDLE;
      count_r <= '0;
      wen_r   <= 1'b0;
      byte_r  <= 1'b0;
      lane_r  <= 2'b00;
    end else begin
      state_r <= state_n;
      count_r <= count_n;
      if (accept) begin
        wen_r  <= mem_if.to_mem_i.wen;
        byte_r <= mem_if.to_mem_i.byte_not_word;
        lane_r <= mem_if.addr_i[1:0];
      end
    end
  end

  always_comb begin
    state_n = state_r;
    count_n = count_r;
    accept  = 1'b0;
    case (state_r)
      DM_IDLE: begin
        accept = mem_if.to_mem_i.valid;
        if (accept) begin
          if (latency_p == 1) begin
            state_n = DM_RESP;
          end else begin
            state_n = DM_WAIT;
            count_n = cnt_w_lp'(latency_p - 1);
          end
        end
      end
      DM_WAIT: begin
        count_n = count_r - 1'b1;
        if (count_r == cnt_w_lp'(1)) state_n = DM_RESP;
      end
      DM_RESP: begin
        if (mem_if.to_mem_i.yumi) state_n = DM_IDLE;
      end
      default: state_n = DM_IDLE;
    endcase
  end

  // Response data is a pure function of registers latched on the acceptance edge.
  always_comb begin
    read_data = array_rdata;
    if (wen_r)       read_data = '0;
    else if (byte_r) read_data = {24'h0, array_rdata[8*lane_r +: 8]};
  end

  assign mem_if.from_mem_o = {read_data, (state_r == DM_RESP), accept};
  assign busy_o            = (state_r != DM_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// tb_data_mem_responder: directed and randomized load/store checks against a word-array model,
// for latency 1 and latency 4 instances. Revision 1.0
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if if1();
  data_mem_responder_if if4();
  logic busy1, busy4;

  mem_in_s     req;
  logic [31:0] req_addr;
  bit          sel;          // 0 -> latency-1 instance, 1 -> latency-4 instance
  mem_out_s    rsp;
  logic        busy;

  assign if1.to_mem_i = sel ? '0 : req;
  assign if4.to_mem_i = sel ? req : '0;
  assign if1.addr_i   = req_addr;
  assign if4.addr_i   = req_addr;
  assign rsp  = sel ? if4.from_mem_o : if1.from_mem_o;
  assign busy = sel ? busy4 : busy1;

  data_mem_responder #(.addr_width_p(10), .latency_p(1)) dut1 (
    .clk(clk), .reset(reset), .mem_if(if1), .busy_o(busy1));
  data_mem_responder #(.addr_width_p(10), .latency_p(4)) dut4 (
    .clk(clk), .reset(reset), .mem_if(if4), .busy_o(busy4));

  logic [31:0] model [2][1024];
  int lat_of [2] = '{1, 4};
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction, started and finished at a falling edge.
  task automatic txn(input bit w, input bit b, input logic [31:0] a,
                     input logic [31:0] wd, input int hold);
    logic [31:0] word, exp_rd;
    logic [9:0]  idx;
    logic [1:0]  ln;
    int lat;
    idx  = a[11:2];
    ln   = a[1:0];
    word = model[sel][idx];
    if (w) begin
      exp_rd = 32'h0;
      if (b) word[8*ln +: 8] = wd[7:0];
      else   word = wd;
      model[sel][idx] = word;
    end else begin
      exp_rd = b ? {24'h0, word[8*ln +: 8]} : word;
    end

    req = '{write_data: wd, valid: 1'b1, wen: w, byte_not_word: b, yumi: 1'b0};
    req_addr = a;
    #1;
    chk("accept_yumi", {31'h0, rsp.yumi}, 32'h1);
    chk("accept_idle", {31'h0, busy}, 32'h0);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp.valid) begin
        req.valid = 1'($urandom_range(0, 1));
        req.yumi  = 1'($urandom_range(0, 1));
        #1;
        chk("wait_no_yumi", {31'h0, rsp.yumi}, 32'h0);
        chk("wait_busy", {31'h0, busy}, 32'h1);
      end
    end while (!rsp.valid && lat < 20);
    chk("latency", lat, lat_of[sel]);
    chk("read_data", rsp.read_data, exp_rd);

    for (int h = 0; h < hold; h++) begin
      req.yumi  = 1'b0;
      req.valid = 1'($urandom_range(0, 1));
      #1;
      chk("resp_no_yumi", {31'h0, rsp.yumi}, 32'h0);
      chk("resp_stable", rsp.read_data, exp_rd);
      @(negedge clk);
    end

    req.yumi  = 1'b1;
    req.valid = 1'b1;
    #1;
    chk("ack_no_accept", {31'h0, rsp.yumi}, 32'h0);
    chk("ack_valid", {31'h0, rsp.valid}, 32'h1);
    @(posedge clk);
    #1;
    req.valid = 1'b0;
    req.yumi  = 1'b0;
    chk("after_ack_valid", {31'h0, rsp.valid}, 32'h0);
    chk("after_ack_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    req = '0;
    req_addr = '0;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_valid", {31'h0, rsp.valid}, 32'h0);
      chk("rst_yumi", {31'h0, rsp.yumi}, 32'h0);
      chk("rst_rdata", rsp.read_data, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Latency 1: word store/load, byte store/loads, aliasing.
    sel = 1'b0;
    txn(1, 0, 32'h10, 32'hDEADBEEF, 0);
    txn(0, 0, 32'h10, 32'h0, 0);
    txn(1, 0, 32'h10, 32'h11223344, 1);
    txn(1, 1, 32'h13, 32'hFFFFFF5A, 0);
    txn(0, 0, 32'h10, 32'h0, 0);
    txn(0, 1, 32'h13, 32'h0, 0);
    txn(0, 1, 32'h11, 32'h0, 2);
    txn(1, 0, 32'h0000_1004, 32'h1, 0);
    txn(0, 0, 32'h4, 32'h0, 0);

    // Latency 4: held response, then reset during the wait of a load.
    sel = 1'b1;
    txn(1, 0, 32'h20, 32'hCAFEF00D, 0);
    txn(0, 0, 32'h20, 32'h0, 3);
    req = '{write_data: 32'h0, valid: 1'b1, wen: 1'b0, byte_not_word: 1'b0, yumi: 1'b0};
    req_addr = 32'h20;
    #1;
    chk("rst_test_accept", {31'h0, rsp.yumi}, 32'h1);
    @(negedge clk);
    req.valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_valid", {31'h0, rsp.valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    txn(0, 0, 32'h20, 32'h0, 0);
    sel = 1'b0;
    txn(0, 0, 32'h10, 32'h0, 0);

    // Randomized traffic over a small word pool with random aliasing bits.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int k = 0; k < 8; k++) txn(1, 0, {20'h0, 10'(64 + k), 2'b00}, $urandom, 0);
      for (int n = 0; n < 30; n++) begin
        r = $urandom;
        txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {r[31:12], 10'(64 + $urandom_range(0, 7)), r[1:0]}, $urandom,
            $urandom_range(0, 2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory endpoint on the core's load/store handshake: accepts one request on the core's `mem_in_s` bundle plus byte address, performs the read or write on an internal word array after a programmable latency, and returns a `mem_out_s` response held until the core acknowledges it. It sits beside `core`, wired `to_mem_o`→`to_mem_i`, `data_mem_addr`→`addr_i`, `from_mem_o`→`from_mem_i`, and replaces the bench-level memory model in single-core and multi-core tops.

## Interface
- `addr_width_p`, 10: word-index bits; array holds 2^addr_width_p 32-bit words.
- `latency_p`, 1: cycles from acceptance to response valid; legal range ≥1.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `to_mem_i`  in  `mem_in_s` (36)  request: `write_data[31:0]`, `valid`, `wen`, `byte_not_word`, `yumi` (core's response acknowledge).
- `addr_i`  in  32  byte address, sampled with `to_mem_i.valid`.
- `from_mem_o`  out  `mem_out_s` (34)  response: `read_data[31:0]`, `valid`, `yumi` (request acceptance).
- `busy_o`  out  1  high in any state other than DM_IDLE.

## Operation
- States: DM_IDLE, DM_WAIT, DM_RESP.
- DM_IDLE: `from_mem_o.yumi = to_mem_i.valid` (combinational; the core relies on same-cycle acceptance). On acceptance, latch wen/byte flag; perform the array access at the closing edge; go to DM_RESP if latency_p=1, else DM_WAIT with counter loaded to latency_p-1.
- DM_WAIT: counter decrements each cycle; at 1 → DM_RESP. Request inputs ignored.
- DM_RESP: `from_mem_o.valid=1`, `read_data` stable. On `to_mem_i.yumi` → DM_IDLE at that edge. `to_mem_i.valid` ignored; no acceptance in the same cycle as response acknowledge (yumi only in DM_IDLE).
- `to_mem_i.yumi` outside DM_RESP: ignored.
- Addressing: word index = `addr_i[addr_width_p+1:2]`; bits above wrap (alias) silently; lane = `addr_i[1:0]`, little-endian, lane k = bits [8k+7:8k].
- Word store: whole word written, `addr_i[1:0]` ignored. Byte store: `write_data[7:0]` to selected lane only, other lanes untouched.
- Word load: returns word. Byte load: returns `{24'b0, lane}` (zero-extended).
- Store response: `read_data = 0`; handshake otherwise identical to a load.
- Read and write of one transaction are at the same edge; a load following a store to the same word in a later transaction sees the new value.

## Timing
- Reset values: `from_mem_o.valid=0`, `from_mem_o.yumi=0` (state DM_IDLE), `read_data=0`, `busy_o=0`, counter 0. Array contents are not reset and survive reset.
- Reset asserted mid-transaction: outstanding transaction dropped, no response; a store already past its acceptance edge remains written.
- Request accepted in cycle T; response valid from cycle T+latency_p; held until the cycle the core raises yumi; earliest next acceptance is the following cycle.
- Minimum load round trip with latency_p=1 and immediate acknowledge: accept T, valid T+1, idle T+2.
- `read_data` registered; changes only on the acceptance edge of a load (or to 0 for a store).

## Structure
- Add `dmem_state_e {DM_IDLE, DM_WAIT, DM_RESP}` to the shared definitions package next to `mem_in_s`/`mem_out_s`; reuse those structs unchanged.
- Sub-module `dmem_array`: synchronous single-port 32-bit array with 4-bit byte-write enable and registered read, parameterized by `addr_width_p`.
- Counter width `$clog2(latency_p+1)`; elaboration-time check that latency_p ≥ 1.

## Test plan
- Word store 0xDEADBEEF to byte addr 0x10, then word load 0x10 (latency_p=1) → yumi same cycle as each valid, load `read_data=0xDEADBEEF` at T+1.
- Byte store 0x5A to addr 0x13 over word 0x11223344, then word load 0x10 → 0x5A223344; byte load 0x13 → 0x0000005A.
- latency_p=4, load held unacknowledged 3 cycles in DM_RESP → valid rises exactly 4 cycles after accept, data stable, `to_mem_i.valid` pulses during DM_WAIT/DM_RESP receive no yumi.
- Address aliasing addr_width_p=10: store 0x1 to 0x0000_1004, load 0x4 → 0x00000001.
- Reset pulse during DM_WAIT of a load → valid never asserts, busy_o=0 next cycle, new request accepted immediately after release; prior stored data intact.
- Back-to-back store then load from `core` running a ST/LD program → core commits both, register holds stored value, no extra yumi pulses.
